switch_led_sequencer: RTL and testbench

Board-level controller that turns the four push switches into mode commands for the four LEDs. Each switch is synchronized and debounced, and its release (falling edge of the debounced level) is used as a command. A small state machine plus a step prescaler sequences the LEDs through off / static / blink / chase patterns. It sits directly between the board switch pins and the LED pins in the top level.

---
 rtl/switch_led_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_switch_led_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_led_sequencer.sv
// ---------------------------------------------------------------------------
// switch_led_sequencer
//
// Turns the four board push switches into mode commands for the four LEDs.
// Each raw switch is synchronized through a 2-flop chain and debounced.
// The release of a switch (debounced level going 1->0) is the command.
// A small mode FSM plus a step prescaler then sequences the LEDs through
// off / static / blink / chase patterns.
//
// Parameters:
//   DEBOUNCE_LIMIT  consecutive cycles a synchronized level must differ from
//                   the stable level before it is accepted (>= 2)
//   STEP_LIMIT      cycles per pattern step: blink half-period and chase
//                   advance (>= 2)
//
// Ports:
//   i_Clk        system clock, all logic on the rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_Switch_1   raw switch: mode advance OFF->STATIC->BLINK->CHASE->OFF
//   i_Switch_2   raw switch: pause/resume stepping
//   i_Switch_3   raw switch: reverse chase direction
//   i_Switch_4   raw switch: clear to OFF (overrides the other switches)
//   o_LED_1..4   registered LED drives
//   o_Mode       current mode: 0 OFF, 1 STATIC, 2 BLINK, 3 CHASE
//   o_Paused     1 while stepping is frozen
// ---------------------------------------------------------------------------
module switch_led_sequencer #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int STEP_LIMIT     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode,
    output logic       o_Paused
);

    localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
    localparam int ST_W = $clog2(STEP_LIMIT);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_LIMIT - 1);

    // Switch bit positions inside the packed switch vectors
    localparam int SW_MODE  = 0;
    localparam int SW_PAUSE = 1;
    localparam int SW_DIR   = 2;
    localparam int SW_CLEAR = 3;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    // Mode advance order, wrapping CHASE back to OFF
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:    next_mode = MODE_STATIC;
            MODE_STATIC: next_mode = MODE_BLINK;
            MODE_BLINK:  next_mode = MODE_CHASE;
            default:     next_mode = MODE_OFF;
        endcase
    endfunction

    // One chase step. Bit 0 is LED1; forward moves toward LED4 and wraps.
    function automatic logic [3:0] rotate_pos(input logic [3:0] pos, input logic rev);
        if (rev) begin
            rotate_pos = {pos[0], pos[3:1]};
        end else begin
            rotate_pos = {pos[2:0], pos[3]};
        end
    endfunction

    function automatic logic [3:0] led_pattern(input mode_t m, input logic phase,
                                               input logic [3:0] pos);
        case (m)
            MODE_OFF:    led_pattern = 4'b0000;
            MODE_STATIC: led_pattern = 4'b1111;
            MODE_BLINK:  led_pattern = {4{phase}};
            default:     led_pattern = pos;
        endcase
    endfunction

    logic [3:0]      sw_raw;
    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      stable_p2;
    logic [3:0]      stable_p3;
    logic [DB_W-1:0] db_cnt_p2 [4];
    logic [3:0]      release_p3;

    assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // ---- stage p0/p1: two-flop synchronizer per switch ----
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_p0 <= 4'b0000;
            sync_p1 <= 4'b0000;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: debounce; a level is accepted only after it has
    // differed from the stable level for DEBOUNCE_LIMIT consecutive cycles ----
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            stable_p2 <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] != stable_p2[i]) begin
                    if (db_cnt_p2[i] == DB_LAST) begin
                        stable_p2[i] <= sync_p1[i];
                        db_cnt_p2[i] <= '0;
                    end else begin
                        db_cnt_p2[i] <= db_cnt_p2[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_p2[i] <= '0;
                end
            end
        end
    end

    // ---- stage p3: delayed stable level for release-edge detection ----
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            stable_p3 <= 4'b0000;
        end else begin
            stable_p3 <= stable_p2;
        end
    end

    // High for exactly one cycle after the stable level falls
    assign release_p3 = stable_p3 & ~stable_p2;

    mode_t           mode_q;
    logic            paused_q;
    logic            dir_q;
    logic            phase_q;
    logic [3:0]      pos_q;
    logic [ST_W-1:0] step_q;
    logic [3:0]      leds_q;

    mode_t           mode_n;
    logic            paused_n;
    logic            dir_n;
    logic            phase_n;
    logic [3:0]      pos_n;
    logic [ST_W-1:0] step_n;

    // ---- stage p4: command decode, prescaler and pattern next-state ----
    always_comb begin
        mode_n   = mode_q;
        paused_n = paused_q;
        dir_n    = dir_q;
        phase_n  = phase_q;
        pos_n    = pos_q;
        step_n   = step_q;

        // Clear wins outright; the other three commands are independent.
        if (release_p3[SW_CLEAR]) begin
            mode_n   = MODE_OFF;
            paused_n = 1'b0;
            dir_n    = 1'b0;
        end else begin
            if (release_p3[SW_MODE]) begin
                mode_n = next_mode(mode_q);
            end
            if (release_p3[SW_PAUSE]) begin
                paused_n = ~paused_q;
            end
            if (release_p3[SW_DIR]) begin
                dir_n = ~dir_q;
            end
        end

        // Entering any mode restarts the pattern from its first step.
        if (mode_n != mode_q) begin
            step_n  = '0;
            phase_n = 1'b1;
            pos_n   = 4'b0001;
        end else if (mode_q == MODE_BLINK || mode_q == MODE_CHASE) begin
            // While paused the count simply holds where it is.
            if (!paused_q) begin
                if (step_q == ST_LAST) begin
                    step_n  = '0;
                    phase_n = ~phase_q;
                    pos_n   = rotate_pos(pos_q, dir_q);
                end else begin
                    step_n = step_q + ST_W'(1);
                end
            end
        end else begin
            step_n = '0;
        end
    end

    // LEDs are registered from the next-state values so they change on
    // the same edge as the mode register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q   <= MODE_OFF;
            paused_q <= 1'b0;
            dir_q    <= 1'b0;
            phase_q  <= 1'b0;
            pos_q    <= 4'b0001;
            step_q   <= '0;
            leds_q   <= 4'b0000;
        end else begin
            mode_q   <= mode_n;
            paused_q <= paused_n;
            dir_q    <= dir_n;
            phase_q  <= phase_n;
            pos_q    <= pos_n;
            step_q   <= step_n;
            leds_q   <= led_pattern(mode_n, phase_n, pos_n);
        end
    end

    assign o_LED_1  = leds_q[0];
    assign o_LED_2  = leds_q[1];
    assign o_LED_3  = leds_q[2];
    assign o_LED_4  = leds_q[3];
    assign o_Mode   = mode_q;
    assign o_Paused = paused_q;

endmodule

// File: tb/tb_switch_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_switch_led_sequencer
//
// Directed bench for switch_led_sequencer with DEBOUNCE_LIMIT=4 and
// STEP_LIMIT=3. Inputs change and outputs are sampled 1 ns after each
// rising edge. A clean release held long enough changes the mode
// registers 7 edges after the switch falls (2 sync + 4 debounce + 1).
// ---------------------------------------------------------------------------
module tb_switch_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       led1, led2, led3, led4;
    logic [1:0] mode;
    logic       paused;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;

    switch_led_sequencer #(
        .DEBOUNCE_LIMIT(4),
        .STEP_LIMIT    (3)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Switch_1(sw[0]),
        .i_Switch_2(sw[1]),
        .i_Switch_3(sw[2]),
        .i_Switch_4(sw[3]),
        .o_LED_1   (led1),
        .o_LED_2   (led2),
        .o_LED_3   (led3),
        .o_LED_4   (led4),
        .o_Mode    (mode),
        .o_Paused  (paused)
    );

    assign leds = {led4, led3, led2, led1};

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Press the masked switches long enough to be accepted, then release;
    // returns 1 ns after the edge on which the command takes effect.
    task automatic release_sw(input logic [3:0] m);
        sw = sw | m;
        cyc(8);
        sw = sw & ~m;
        cyc(7);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sw    = 4'b0000;
        cyc(2);
        check("reset_leds",   leds,            4'b0000);
        check("reset_mode",   {2'b00, mode},   4'd0);
        check("reset_paused", {3'b000, paused}, 4'd0);
        rst_n = 1'b1;
        cyc(2);

        // Bounce: 2-cycle pulses never satisfy the 4-cycle debounce
        repeat (5) begin
            sw[0] = 1'b1;
            cyc(2);
            sw[0] = 1'b0;
            cyc(2);
        end
        cyc(8);
        check("bounce_mode", {2'b00, mode}, 4'd0);
        check("bounce_leds", leds,          4'b0000);

        sw[0] = 1'b1;
        cyc(10);
        sw[0] = 1'b0;
        cyc(6);
        check("latency_before", {2'b00, mode}, 4'd0);
        cyc(1);
        check("latency_mode", {2'b00, mode}, 4'd1);
        check("latency_leds", leds,          4'b1111);

        release_sw(4'b1000);
        check("clear_mode", {2'b00, mode}, 4'd0);
        check("clear_leds", leds,          4'b0000);

        // Mode walk
        release_sw(4'b0001);
        check("walk_static_mode", {2'b00, mode}, 4'd1);
        check("walk_static_leds", leds,          4'b1111);
        release_sw(4'b0001);
        check("walk_blink_mode", {2'b00, mode}, 4'd2);
        check("blink_c0", leds, 4'b1111);
        cyc(1);
        check("blink_c1", leds, 4'b1111);
        cyc(1);
        check("blink_c2", leds, 4'b1111);
        cyc(1);
        check("blink_tick1", leds, 4'b0000);
        cyc(3);
        check("blink_tick2", leds, 4'b1111);
        release_sw(4'b0001);
        check("walk_chase_mode", {2'b00, mode}, 4'd3);
        check("walk_chase_leds", leds,          4'b0001);
        release_sw(4'b0001);
        check("walk_off_mode", {2'b00, mode}, 4'd0);
        check("walk_off_leds", leds,          4'b0000);

        // Chase forward full lap, then reverse while on LED3
        release_sw(4'b0001);
        release_sw(4'b0001);
        release_sw(4'b0001);
        check("chase_mode", {2'b00, mode}, 4'd3);
        check("chase_e0", leds, 4'b0001);
        sw[2] = 1'b1;
        cyc(3);
        check("chase_e3", leds, 4'b0010);
        cyc(3);
        check("chase_e6", leds, 4'b0100);
        cyc(3);
        check("chase_e9", leds, 4'b1000);
        cyc(3);
        check("chase_e12_wrap", leds, 4'b0001);
        sw[2] = 1'b0;
        cyc(3);
        check("chase_e15", leds, 4'b0010);
        cyc(3);
        check("chase_e18", leds, 4'b0100);
        cyc(3);
        check("chase_rev_e21", leds, 4'b0010);
        cyc(3);
        check("chase_rev_e24", leds, 4'b0001);
        cyc(3);
        check("chase_rev_wrap", leds, 4'b1000);

        // Asynchronous reset mid-chase, checked between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_leds",   leds,             4'b0000);
        check("async_rst_mode",   {2'b00, mode},    4'd0);
        check("async_rst_paused", {3'b000, paused}, 4'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Pause in BLINK: pause lands with held count 1 and phase 1
        release_sw(4'b0001);
        release_sw(4'b0001);
        check("pause_blink_mode", {2'b00, mode}, 4'd2);
        cyc(4);
        release_sw(4'b0010);
        check("pause_on",      {3'b000, paused}, 4'd1);
        check("pause_on_leds", leds,             4'b1111);
        sw[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("pause_frozen", leds, 4'b1111);
        end
        sw[1] = 1'b0;
        cyc(6);
        check("resume_before", {3'b000, paused}, 4'd1);
        cyc(1);
        check("resume_paused", {3'b000, paused}, 4'd0);
        check("resume_r0",     leds,             4'b1111);
        cyc(1);
        check("resume_r1", leds, 4'b1111);
        cyc(1);
        check("resume_tick", leds, 4'b0000);

        // Priority: SW4 with SW1 and SW3 in the same cycle, paused BLINK
        release_sw(4'b0010);
        check("prio_paused_pre", {3'b000, paused}, 4'd1);
        sw = sw | 4'b1101;
        cyc(8);
        sw = sw & ~4'b1101;
        cyc(6);
        check("prio_before", {2'b00, mode}, 4'd2);
        cyc(1);
        check("prio_mode",   {2'b00, mode},    4'd0);
        check("prio_paused", {3'b000, paused}, 4'd0);
        check("prio_leds",   leds,             4'b0000);

        // SW1 and SW2 together both apply; pause in STATIC only recorded
        release_sw(4'b0011);
        check("dual_static_mode",   {2'b00, mode},    4'd1);
        check("dual_static_paused", {3'b000, paused}, 4'd1);
        check("dual_static_leds",   leds,             4'b1111);
        release_sw(4'b0011);
        check("dual_blink_mode",   {2'b00, mode},    4'd2);
        check("dual_blink_paused", {3'b000, paused}, 4'd0);
        release_sw(4'b0001);
        check("fwd_after_clear_e0", leds, 4'b0001);
        cyc(3);
        check("fwd_after_clear_e3", leds, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
